// File: rtl/count_run_ctrl.sv
// Run/pause/clear FSM, count-enable prescaler and 3-digit segment scan for a 0-999 BCD counter.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits on the shared segment bus.
module count_run_ctrl #(
  parameter int PRESCALE = 50000,
  parameter int SCAN_DIV = 1000,
  parameter bit WRAP     = 1'b1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       at_max,
  input  logic [6:0] uni,
  input  logic [6:0] dez,
  input  logic [6:0] cen,
  output logic       cnt_en,
  output logic       cnt_clr_n,
  output logic [6:0] seg,
  output logic [2:0] dig,
  output logic [1:0] state,
  output logic       running
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] RUN   = 2'b01;
  localparam logic [1:0] PAUSE = 2'b10;
  localparam logic [1:0] DONE  = 2'b11;

  localparam int PW = $clog2(PRESCALE);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic          ss_q;
  logic [PW-1:0] pc;
  logic [SW-1:0] sc;
  logic          se;
  logic          pc_term;
  logic          term;
  logic          stop;
  logic          sc_term;
  logic [1:0]    state_nxt;
  logic [PW-1:0] pc_nxt;
  logic [2:0]    dig_nxt;
  logic [6:0]    seg_nxt;
  logic [6:0]    cen_v;
  logic [6:0]    dez_v;

  assign se      = start_stop & ~ss_q;
  assign pc_term = (pc == PW'(PRESCALE - 1));
  assign term    = (state == RUN) & pc_term;
  assign stop    = at_max & ~WRAP;
  assign sc_term = (sc == SW'(SCAN_DIV - 1));

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (se) state_nxt = RUN;
        RUN: begin
          if (se)
            state_nxt = PAUSE;
          else if (term && stop)
            state_nxt = DONE;
        end
        PAUSE:   if (se) state_nxt = RUN;
        default: state_nxt = DONE;
      endcase
    end
  end

  // The pausing edge does not consume a prescaler cycle.
  always_comb begin
    pc_nxt = pc;
    if (clear || state == IDLE)
      pc_nxt = '0;
    else if (state == RUN) begin
      if (pc_term)
        pc_nxt = '0;
      else if (!se)
        pc_nxt = pc + PW'(1);
    end
  end

  always_comb begin
    cen_v = cen;
    dez_v = dez;
`ifdef LEADING_ZERO_BLANK_EN
    if (cen == 7'b0111111) begin
      cen_v = '0;
      if (dez == 7'b0111111)
        dez_v = '0;
    end
`endif
  end

  assign dig_nxt = sc_term ? {dig[1:0], dig[2]} : dig;

  always_comb begin
    seg_nxt = '0;
    unique case (1'b1)
      dig_nxt[0]: seg_nxt = uni;
      dig_nxt[1]: seg_nxt = dez_v;
      dig_nxt[2]: seg_nxt = cen_v;
      default:    seg_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ss_q      <= 1'b0;
      state     <= IDLE;
      running   <= 1'b0;
      pc        <= '0;
      cnt_en    <= 1'b0;
      cnt_clr_n <= 1'b1;
    end else begin
      ss_q      <= start_stop;
      state     <= state_nxt;
      running   <= (state_nxt == RUN);
      pc        <= pc_nxt;
      cnt_en    <= term & ~stop & ~clear;
      cnt_clr_n <= ~clear;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sc  <= '0;
      dig <= 3'b001;
      seg <= '0;
    end else begin
      sc  <= sc_term ? '0 : sc + SW'(1);
      dig <= dig_nxt;
      seg <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_count_run_ctrl.sv
// Directed bench for count_run_ctrl with PRESCALE=4, SCAN_DIV=2.
// A WRAP=1 and a WRAP=0 instance share every input.
module tb_count_run_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start_stop;
  logic       clear;
  logic       at_max;
  logic [6:0] uni, dez, cen;

  logic       cnt_en, cnt_clr_n, running;
  logic [6:0] seg;
  logic [2:0] dig;
  logic [1:0] state;

  logic       nw_cnt_en, nw_cnt_clr_n, nw_running;
  logic [6:0] nw_seg;
  logic [2:0] nw_dig;
  logic [1:0] nw_state;

  int n_chk  = 0;
  int n_fail = 0;

  logic       m_sc;
  logic [2:0] m_dig;

  always #5 clk = ~clk;

  count_run_ctrl #(.PRESCALE(4), .SCAN_DIV(2), .WRAP(1'b1)) u_dut (
    .clk(clk), .rstn(rstn), .start_stop(start_stop), .clear(clear),
    .at_max(at_max), .uni(uni), .dez(dez), .cen(cen),
    .cnt_en(cnt_en), .cnt_clr_n(cnt_clr_n), .seg(seg), .dig(dig),
    .state(state), .running(running)
  );

  count_run_ctrl #(.PRESCALE(4), .SCAN_DIV(2), .WRAP(1'b0)) u_nw (
    .clk(clk), .rstn(rstn), .start_stop(start_stop), .clear(clear),
    .at_max(at_max), .uni(uni), .dez(dez), .cen(cen),
    .cnt_en(nw_cnt_en), .cnt_clr_n(nw_cnt_clr_n), .seg(nw_seg),
    .dig(nw_dig), .state(nw_state), .running(nw_running)
  );

  // Reference scan position: two cycles per digit, rotating in every state.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_sc  <= 1'b0;
      m_dig <= 3'b001;
    end else begin
      m_sc <= ~m_sc;
      if (m_sc)
        m_dig <= {m_dig[1:0], m_dig[2]};
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [2:0] dseq [6];
    logic [6:0] sseq [6];
    logic [6:0] exp_seg;

    rstn = 1'b0; start_stop = 1'b0; clear = 1'b0; at_max = 1'b0;
    uni = 7'h06; dez = 7'h5b; cen = 7'h4f;
    repeat (2) @(negedge clk);
    check("rst_state", state, 2'b00);
    check("rst_running", running, 1'b0);
    check("rst_cnt_en", cnt_en, 1'b0);
    check("rst_clr_n", cnt_clr_n, 1'b1);
    check("rst_dig", dig, 3'b001);
    check("rst_seg", seg, 7'h00);

    rstn = 1'b1;
    dseq = '{3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001};
    sseq = '{7'h06, 7'h5b, 7'h5b, 7'h4f, 7'h4f, 7'h06};
    for (int i = 0; i < 6; i++) begin
      step();
      check("scan_dig", dig, dseq[i]);
      check("scan_seg", seg, sseq[i]);
      check("idle_en", cnt_en, 1'b0);
    end
    uni = 7'h3f;
    check("seg_latency_old", seg, 7'h06);
    step();
    check("seg_latency_new", seg, 7'h3f);
    check("dig_hold", dig, 3'b001);
    for (int i = 0; i < 13; i++) begin
      step();
      check("idle_en", cnt_en, 1'b0);
      check("idle_state", state, 2'b00);
    end

    start_stop = 1'b1;
    step();
    start_stop = 1'b0;
    check("start_state", state, 2'b01);
    check("start_running", running, 1'b1);
    check("start_en", cnt_en, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      step();
      check("run_en", cnt_en, (k % 4) == 0);
    end
    step();
    step();
    start_stop = 1'b1;
    step();
    start_stop = 1'b0;
    check("pause_state", state, 2'b10);
    check("pause_running", running, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("pause_en", cnt_en, 1'b0);
      check("pause_hold", state, 2'b10);
    end
    start_stop = 1'b1;
    step();
    start_stop = 1'b0;
    check("resume_state", state, 2'b01);
    check("resume_en0", cnt_en, 1'b0);
    step();
    check("resume_en1", cnt_en, 1'b0);
    step();
    check("resume_en2", cnt_en, 1'b1);

    step();
    start_stop = 1'b1;
    step();
    start_stop = 1'b0;
    check("pause2_state", state, 2'b10);
    step();
    clear = 1'b1; start_stop = 1'b1;
    step();
    clear = 1'b0; start_stop = 1'b0;
    check("clr_state", state, 2'b00);
    check("clr_clr_n", cnt_clr_n, 1'b0);
    check("clr_en", cnt_en, 1'b0);
    check("clr_running", running, 1'b0);
    step();
    check("clr_release", cnt_clr_n, 1'b1);
    check("clr_idle", state, 2'b00);

    start_stop = 1'b1;
    step();
    start_stop = 1'b0;
    check("restart_state", state, 2'b01);
    for (int k = 1; k <= 4; k++) begin
      step();
      check("restart_en", cnt_en, k == 4);
    end
    step();
    clear = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_clr_n", cnt_clr_n, 1'b0);
      check("hold_state", state, 2'b00);
      check("hold_en", cnt_en, 1'b0);
    end
    clear = 1'b0;
    step();
    check("hold_release", cnt_clr_n, 1'b1);

    start_stop = 1'b1;
    step();
    start_stop = 1'b0;
    at_max = 1'b1;
    check("nw_start", nw_state, 2'b01);
    for (int k = 1; k <= 3; k++) begin
      step();
      check("nw_en", nw_cnt_en, 1'b0);
    end
    step();
    check("wrap_en", cnt_en, 1'b1);
    check("wrap_state", state, 2'b01);
    check("done_en", nw_cnt_en, 1'b0);
    check("done_state", nw_state, 2'b11);
    check("done_running", nw_running, 1'b0);
    start_stop = 1'b1;
    step();
    start_stop = 1'b0;
    check("done_ignore_se", nw_state, 2'b11);
    step();
    check("done_stay", nw_state, 2'b11);
    check("done_en2", nw_cnt_en, 1'b0);
    clear = 1'b1;
    step();
    clear = 1'b0; at_max = 1'b0;
    check("done_clr", nw_state, 2'b00);
    check("done_clr_n", nw_cnt_clr_n, 1'b0);
    check("wrap_clr", state, 2'b00);

    uni = 7'h06; dez = 7'h3f; cen = 7'h3f;
    for (int i = 0; i < 6; i++) begin
      step();
      check("blank_dig", dig, m_dig);
      exp_seg = 7'h3f;
`ifdef LEADING_ZERO_BLANK_EN
      exp_seg = 7'h00;
`endif
      if (m_dig == 3'b001)
        exp_seg = 7'h06;
      check("blank_seg", seg, exp_seg);
    end

    start_stop = 1'b1;
    step();
    start_stop = 1'b0;
    step();
    step();
    rstn = 1'b0;
    #1;
    check("arst_state", state, 2'b00);
    check("arst_running", running, 1'b0);
    check("arst_dig", dig, 3'b001);
    check("arst_seg", seg, 7'h00);
    check("arst_clr_n", cnt_clr_n, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
